// File: rtl/mem_access.sv
// mem_access: memory stage; issues load/store on a req/gnt/rvalid bus.
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_access #(
   parameter int ADDR_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic                  ex_w_reg_enable_i,
   input  logic                  mem_w_reg_enable_i,
   input  logic [REG_ADDR_W-1:0] w_reg_addr_i,
   input  logic [31:0]           ex_w_reg_data_i,
   input  logic                  w_mem_enable_i,
   input  logic [ADDR_W-1:0]     w_mem_addr_i,
   input  logic [31:0]           w_mem_data_i,
   input  logic                  r_mem_enable_i,
   input  logic [ADDR_W-1:0]     r_mem_addr_i,
   input  logic [2:0]            data_type_i,
   output logic                  hold_o,
   output logic                  bus_req_o,
   output logic                  bus_we_o,
   output logic [ADDR_W-1:0]     bus_addr_o,
   output logic [31:0]           bus_wdata_o,
   output logic [3:0]            bus_wstrb_o,
   input  logic                  bus_gnt_i,
   input  logic                  bus_rvalid_i,
   input  logic [31:0]           bus_rdata_i,
   output logic                  wb_reg_enable_o,
   output logic [REG_ADDR_W-1:0] wb_reg_addr_o,
   output logic [31:0]           wb_reg_data_o,
   output logic                  misalign_o,
   output logic [ADDR_W-1:0]     misalign_addr_o
);

`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t                state;
   logic                  op_load;
   logic                  op_wen;
   logic [2:0]            op_type;
   logic [1:0]            op_off;
   logic [REG_ADDR_W-1:0] op_dest;

   logic                  mem_op;
   logic                  is_store;
   logic                  misalign;
   logic                  trap;
   logic [ADDR_W-1:0]     in_addr;
   logic [ADDR_W-1:0]     fix_addr;
   logic [3:0]            lane_strb;
   logic [31:0]           lane_wdata;
   logic [31:0]           rd_shift;
   logic [15:0]           rd_half;
   logic [31:0]           load_data;

   // decode the incoming request: address select, alignment, store lanes
   always_comb begin
      is_store = w_mem_enable_i;
      mem_op   = w_mem_enable_i | r_mem_enable_i;
      in_addr  = is_store ? w_mem_addr_i : r_mem_addr_i;
      misalign = ((data_type_i == 3'b010 || data_type_i == 3'b110) && in_addr[0])
               || (data_type_i == 3'b011 && in_addr[1:0] != 2'b00);
      trap     = TRAP_EN && misalign;
      fix_addr = in_addr;
      if (!TRAP_EN) begin
         if (data_type_i == 3'b010 || data_type_i == 3'b110)
            fix_addr[0] = 1'b0;
         else if (data_type_i == 3'b011)
            fix_addr[1:0] = 2'b00;
      end
      lane_strb  = 4'b0000;
      lane_wdata = w_mem_data_i;
      unique case (data_type_i)
         3'b001, 3'b101: begin
            lane_strb  = 4'b0001 << fix_addr[1:0];
            lane_wdata = {4{w_mem_data_i[7:0]}};
         end
         3'b010, 3'b110: begin
            lane_strb  = 4'b0011 << fix_addr[1:0];
            lane_wdata = {2{w_mem_data_i[15:0]}};
         end
         3'b011: lane_strb = 4'b1111;
         default: lane_strb = 4'b0000;
      endcase
   end

   // extract and extend load data using the latched offset and type
   always_comb begin
      rd_shift  = bus_rdata_i >> {op_off, 3'b000};
      rd_half   = op_off[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
      load_data = bus_rdata_i;
      unique case (op_type)
         3'b001: load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b101: load_data = {24'h0, rd_shift[7:0]};
         3'b010: load_data = {{16{rd_half[15]}}, rd_half};
         3'b110: load_data = {16'h0, rd_half};
         default: load_data = bus_rdata_i;
      endcase
   end

   // stall upstream while a transaction is accepted or outstanding
   always_comb begin
      hold_o = 1'b0;
      unique case (state)
         IDLE:    hold_o = mem_op && !flush_i && !trap;
         REQ:     hold_o = !(bus_gnt_i && bus_rvalid_i);
         RESP:    hold_o = !bus_rvalid_i;
         default: hold_o = 1'b0;
      endcase
      if (rst) hold_o = 1'b0;
   end

   // bus FSM with registered bus, write-back and misalign outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         op_load         <= 1'b0;
         op_wen          <= 1'b0;
         op_type         <= 3'b000;
         op_off          <= 2'b00;
         op_dest         <= '0;
         bus_req_o       <= 1'b0;
         bus_we_o        <= 1'b0;
         bus_addr_o      <= '0;
         bus_wdata_o     <= '0;
         bus_wstrb_o     <= 4'b0000;
         wb_reg_enable_o <= 1'b0;
         wb_reg_addr_o   <= '0;
         wb_reg_data_o   <= '0;
         misalign_o      <= 1'b0;
         misalign_addr_o <= '0;
      end else begin
         wb_reg_enable_o <= 1'b0;
         misalign_o      <= 1'b0;
         misalign_addr_o <= '0;
         unique case (state)
            IDLE: begin
               if (flush_i) begin
                  wb_reg_enable_o <= 1'b0;
               end else if (mem_op && trap) begin
                  misalign_o      <= 1'b1;
                  misalign_addr_o <= in_addr;
               end else if (mem_op) begin
                  state       <= REQ;
                  bus_req_o   <= 1'b1;
                  bus_we_o    <= is_store;
                  bus_addr_o  <= {fix_addr[ADDR_W-1:2], 2'b00};
                  bus_wdata_o <= is_store ? lane_wdata : 32'h0;
                  bus_wstrb_o <= is_store ? lane_strb : 4'b0000;
                  op_load     <= !is_store;
                  op_wen      <= mem_w_reg_enable_i;
                  op_type     <= data_type_i;
                  op_off      <= fix_addr[1:0];
                  op_dest     <= w_reg_addr_i;
               end else begin
                  wb_reg_enable_o <= ex_w_reg_enable_i && (w_reg_addr_i != '0);
                  wb_reg_addr_o   <= w_reg_addr_i;
                  wb_reg_data_o   <= ex_w_reg_data_i;
               end
            end
            REQ: begin
               if (bus_gnt_i) begin
                  bus_req_o   <= 1'b0;
                  bus_we_o    <= 1'b0;
                  bus_addr_o  <= '0;
                  bus_wdata_o <= '0;
                  bus_wstrb_o <= 4'b0000;
                  state       <= bus_rvalid_i ? IDLE : RESP;
                  if (bus_rvalid_i && op_load) begin
                     wb_reg_enable_o <= op_wen && (op_dest != '0);
                     wb_reg_addr_o   <= op_dest;
                     wb_reg_data_o   <= load_data;
                  end
               end
            end
            RESP: begin
               if (bus_rvalid_i) begin
                  state <= IDLE;
                  if (op_load) begin
                     wb_reg_enable_o <= op_wen && (op_dest != '0);
                     wb_reg_addr_o   <= op_dest;
                     wb_reg_data_o   <= load_data;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed checks of the mem_access memory stage.
// Covers ALU pass-through, loads, stores, flush, misalign, reset.
module tb_mem_access;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        ex_en;
   logic        mem_en;
   logic [4:0]  wreg;
   logic [31:0] ex_data;
   logic        w_en;
   logic [31:0] w_addr;
   logic [31:0] w_data;
   logic        r_en;
   logic [31:0] r_addr;
   logic [2:0]  dtype;
   logic        hold;
   logic        req;
   logic        we;
   logic [31:0] baddr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        mis;
   logic [31:0] mis_addr;

   int checks = 0;
   int errors = 0;

   mem_access dut (
      .clk                (clk),
      .rst                (rst),
      .flush_i            (flush),
      .ex_w_reg_enable_i  (ex_en),
      .mem_w_reg_enable_i (mem_en),
      .w_reg_addr_i       (wreg),
      .ex_w_reg_data_i    (ex_data),
      .w_mem_enable_i     (w_en),
      .w_mem_addr_i       (w_addr),
      .w_mem_data_i       (w_data),
      .r_mem_enable_i     (r_en),
      .r_mem_addr_i       (r_addr),
      .data_type_i        (dtype),
      .hold_o             (hold),
      .bus_req_o          (req),
      .bus_we_o           (we),
      .bus_addr_o         (baddr),
      .bus_wdata_o        (wdata),
      .bus_wstrb_o        (wstrb),
      .bus_gnt_i          (gnt),
      .bus_rvalid_i       (rvalid),
      .bus_rdata_i        (rdata),
      .wb_reg_enable_o    (wb_en),
      .wb_reg_addr_o      (wb_addr),
      .wb_reg_data_o      (wb_data),
      .misalign_o         (mis),
      .misalign_addr_o    (mis_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      flush   = 1'b0;
      ex_en   = 1'b0;
      mem_en  = 1'b0;
      wreg    = 5'd0;
      ex_data = 32'h0;
      w_en    = 1'b0;
      w_addr  = 32'h0;
      w_data  = 32'h0;
      r_en    = 1'b0;
      r_addr  = 32'h0;
      dtype   = 3'b000;
      gnt     = 1'b0;
      rvalid  = 1'b0;
      rdata   = 32'h0;
   endtask

   task automatic mem_txn(input string tag, input bit st,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] ty, input logic [4:0] dest,
                          input int gw, input bit same,
                          input logic [31:0] rd, input logic [31:0] e_addr,
                          input logic [3:0] e_strb, input logic [31:0] e_wdata,
                          input bit e_wb, input logic [31:0] e_data);
      if (st) begin
         w_en = 1'b1; w_addr = a; w_data = d;
      end else begin
         r_en = 1'b1; r_addr = a; mem_en = 1'b1;
      end
      dtype = ty;
      wreg  = dest;
      @(negedge clk);
      chk({tag, ".hold_acc"}, 32'(hold), 32'd1);
      tick();
      chk({tag, ".req"}, 32'(req), 32'd1);
      chk({tag, ".addr"}, baddr, e_addr);
      chk({tag, ".we"}, 32'(we), 32'(st));
      chk({tag, ".strb"}, 32'(wstrb), 32'(e_strb));
      chk({tag, ".wdata"}, wdata, e_wdata);
      chk({tag, ".wb_acc"}, 32'(wb_en), 32'd0);
      for (int i = 0; i < gw; i++) begin
         @(negedge clk);
         chk({tag, ".hold_wait"}, 32'(hold), 32'd1);
         tick();
         chk({tag, ".req_wait"}, 32'(req), 32'd1);
         chk({tag, ".addr_wait"}, baddr, e_addr);
      end
      gnt    = 1'b1;
      rvalid = same;
      rdata  = rd;
      if (!same) begin
         @(negedge clk);
         chk({tag, ".hold_gnt"}, 32'(hold), 32'd1);
         tick();
         gnt = 1'b0;
         chk({tag, ".req_resp"}, 32'(req), 32'd0);
         rvalid = 1'b1;
      end
      @(negedge clk);
      chk({tag, ".hold_done"}, 32'(hold), 32'd0);
      tick();
      clr();
      chk({tag, ".wb_en"}, 32'(wb_en), 32'(e_wb));
      if (e_wb) begin
         chk({tag, ".wb_addr"}, 32'(wb_addr), 32'(dest));
         chk({tag, ".wb_data"}, wb_data, e_data);
      end
      chk({tag, ".req_idle"}, 32'(req), 32'd0);
   endtask

   initial begin
      clr();
      rst = 1'b1;
      r_en = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      chk("rst.hold", 32'(hold), 32'd0);
      chk("rst.req", 32'(req), 32'd0);
      chk("rst.we", 32'(we), 32'd0);
      chk("rst.addr", baddr, 32'h0);
      chk("rst.wdata", wdata, 32'h0);
      chk("rst.strb", 32'(wstrb), 32'd0);
      chk("rst.wb_en", 32'(wb_en), 32'd0);
      chk("rst.wb_addr", 32'(wb_addr), 32'd0);
      chk("rst.wb_data", wb_data, 32'h0);
      chk("rst.mis", 32'(mis), 32'd0);
      chk("rst.mis_addr", mis_addr, 32'h0);
      tick();
      clr();
      rst = 1'b0;

      // ALU write-back, one cycle latency
      ex_en = 1'b1; wreg = 5'd5; ex_data = 32'h1234;
      @(negedge clk);
      chk("alu.hold", 32'(hold), 32'd0);
      tick();
      clr();
      chk("alu.wb_en", 32'(wb_en), 32'd1);
      chk("alu.wb_addr", 32'(wb_addr), 32'd5);
      chk("alu.wb_data", wb_data, 32'h1234);

      // ALU to x0 is not written
      ex_en = 1'b1; wreg = 5'd0; ex_data = 32'h77;
      tick();
      clr();
      chk("alu_x0.wb_en", 32'(wb_en), 32'd0);

      // flushed ALU op
      ex_en = 1'b1; wreg = 5'd3; ex_data = 32'h99; flush = 1'b1;
      tick();
      clr();
      chk("flush_alu.wb_en", 32'(wb_en), 32'd0);

      // flushed load: nothing issued, no stall
      r_en = 1'b1; r_addr = 32'h1000; dtype = 3'b011; wreg = 5'd2;
      mem_en = 1'b1; flush = 1'b1;
      @(negedge clk);
      chk("flush_ld.hold", 32'(hold), 32'd0);
      tick();
      clr();
      chk("flush_ld.req", 32'(req), 32'd0);
      chk("flush_ld.wb_en", 32'(wb_en), 32'd0);

      mem_txn("lb", 1'b0, 32'h1003, 32'h0, 3'b001, 5'd7, 2, 1'b0,
              32'h80FF_0000, 32'h1000, 4'b0000, 32'h0, 1'b1, 32'hFFFF_FF80);
      mem_txn("lbu", 1'b0, 32'h1003, 32'h0, 3'b101, 5'd7, 2, 1'b0,
              32'h80FF_0000, 32'h1000, 4'b0000, 32'h0, 1'b1, 32'h0000_0080);
      mem_txn("sh", 1'b1, 32'h2002, 32'h0000_ABCD, 3'b010, 5'd0, 0, 1'b0,
              32'h0, 32'h2000, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0);
      mem_txn("sb", 1'b1, 32'h5001, 32'hFFFF_FF12, 3'b001, 5'd0, 1, 1'b1,
              32'h0, 32'h5000, 4'b0010, 32'h1212_1212, 1'b0, 32'h0);
      mem_txn("sw", 1'b1, 32'h5004, 32'hCAFE_F00D, 3'b011, 5'd0, 0, 1'b1,
              32'h0, 32'h5004, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0);
      mem_txn("lw_x0", 1'b0, 32'h4000, 32'h0, 3'b011, 5'd0, 0, 1'b1,
              32'hDEAD_BEEF, 32'h4000, 4'b0000, 32'h0, 1'b0, 32'h0);
      mem_txn("lw", 1'b0, 32'h4000, 32'h0, 3'b011, 5'd8, 0, 1'b1,
              32'hDEAD_BEEF, 32'h4000, 4'b0000, 32'h0, 1'b1, 32'hDEAD_BEEF);
      mem_txn("lhu", 1'b0, 32'h4002, 32'h0, 3'b110, 5'd10, 0, 1'b0,
              32'h8001_1234, 32'h4000, 4'b0000, 32'h0, 1'b1, 32'h0000_8001);
      mem_txn("lh", 1'b0, 32'h4002, 32'h0, 3'b010, 5'd11, 0, 1'b0,
              32'h8001_1234, 32'h4000, 4'b0000, 32'h0, 1'b1, 32'hFFFF_8001);
      mem_txn("lb1", 1'b0, 32'h4001, 32'h0, 3'b001, 5'd12, 0, 1'b1,
              32'h0000_5A00, 32'h4000, 4'b0000, 32'h0, 1'b1, 32'h0000_005A);

`ifdef MEM_MISALIGN_TRAP_EN
      r_en = 1'b1; r_addr = 32'h3001; dtype = 3'b011; wreg = 5'd9;
      mem_en = 1'b1;
      @(negedge clk);
      chk("mis.hold", 32'(hold), 32'd0);
      tick();
      clr();
      chk("mis.pulse", 32'(mis), 32'd1);
      chk("mis.addr", mis_addr, 32'h3001);
      chk("mis.req", 32'(req), 32'd0);
      chk("mis.wb_en", 32'(wb_en), 32'd0);
      tick();
      chk("mis.pulse_end", 32'(mis), 32'd0);
      chk("mis.req_end", 32'(req), 32'd0);
`else
      mem_txn("mis_lw", 1'b0, 32'h3001, 32'h0, 3'b011, 5'd9, 0, 1'b0,
              32'h1122_3344, 32'h3000, 4'b0000, 32'h0, 1'b1, 32'h1122_3344);
      chk("mis.none", 32'(mis), 32'd0);
`endif

      // reset while waiting for rvalid
      r_en = 1'b1; r_addr = 32'h6000; dtype = 3'b011; wreg = 5'd4;
      mem_en = 1'b1;
      tick();
      gnt = 1'b1;
      tick();
      gnt = 1'b0;
      chk("rstmid.resp", 32'(req), 32'd0);
      rst = 1'b1;
      clr();
      @(negedge clk);
      chk("rstmid.hold", 32'(hold), 32'd0);
      tick();
      rst = 1'b0;
      chk("rstmid.wb_en", 32'(wb_en), 32'd0);
      chk("rstmid.req", 32'(req), 32'd0);
      rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("late.hold", 32'(hold), 32'd0);
      tick();
      clr();
      chk("late.wb_en", 32'(wb_en), 32'd0);
      chk("late.req", 32'(req), 32'd0);
      ex_en = 1'b1; wreg = 5'd6; ex_data = 32'h55;
      tick();
      clr();
      chk("post.wb_en", 32'(wb_en), 32'd1);
      chk("post.wb_data", wb_data, 32'h55);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage sitting directly downstream of the execute stage.
- Consumes the execute stage's write-back, load and store requests. Issues load/store transactions on a req/gnt/rvalid data bus with byte-lane alignment, byte strobes and load sign/zero extension.
- Produces a registered write-back record for the register file.
- Raises hold_o to stall upstream stages while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, byte address width of the data bus.
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  discard the incoming (IDLE-cycle) instruction
- ex_w_reg_enable_i  in  1  execute result to be written back
- mem_w_reg_enable_i  in  1  load result to be written back
- w_reg_addr_i  in  REG_ADDR_W  destination register
- ex_w_reg_data_i  in  32  execute result
- w_mem_enable_i  in  1  store request
- w_mem_addr_i  in  ADDR_W  store byte address
- w_mem_data_i  in  32  store data, right-justified
- r_mem_enable_i  in  1  load request
- r_mem_addr_i  in  ADDR_W  load byte address
- data_type_i  in  3  000 none, 001 byte, 010 half, 011 word, 101 byte unsigned, 110 half unsigned
- hold_o  out  1  stall upstream; upstream keeps inputs stable while high
- bus_req_o  out  1  transaction request
- bus_we_o  out  1  1 = write
- bus_addr_o  out  ADDR_W  word-aligned address, low 2 bits forced to 0
- bus_wdata_o  out  32  lane-replicated store data
- bus_wstrb_o  out  4  byte strobes; 0000 on reads
- bus_gnt_i  in  1  request accepted
- bus_rvalid_i  in  1  response or ack valid
- bus_rdata_i  in  32  read data
- wb_reg_enable_o  out  1  register-file write enable
- wb_reg_addr_o  out  REG_ADDR_W  write-back address
- wb_reg_data_o  out  32  write-back data
- misalign_o  out  1  one-cycle misaligned-access pulse
- misalign_addr_o  out  ADDR_W  faulting byte address

Behaviour:
- Reset: every output is 0; state returns to IDLE.
- A mem op is present when w_mem_enable_i or r_mem_enable_i is high.
- If both enables are high, the op is a store and the read is ignored.
- States are IDLE, REQ and RESP.

IDLE:
- No mem op and no flush: next cycle, wb_reg_enable_o = ex_w_reg_enable_i && (w_reg_addr_i != 0), with addr and data copied. Latency is 1 cycle.
- Mem op, aligned, no flush: latch the op (address, data, type, dest, load/store), then go to REQ. hold_o is high in this same cycle, combinationally from the inputs. wb_reg_enable_o is 0 next cycle.
- flush_i high: the input is discarded, nothing is issued, and wb_reg_enable_o is 0 next cycle.
- bus_rvalid_i is ignored in IDLE.

REQ:
- bus_req_o is high, and bus_addr_o / bus_we_o / bus_wdata_o / bus_wstrb_o are driven from the latched op. All are stable until gnt.
- gnt without rvalid: go to RESP.
- gnt with rvalid in the same cycle: complete directly.

RESP:
- bus_req_o is 0; wait for bus_rvalid_i.
- Completion cycle: hold_o drops to 0 and state goes to IDLE.
  - Load: next cycle wb_reg_enable_o = (dest != 0), with wb_reg_data_o the extracted data.
  - Store: wb_reg_enable_o is 0.
- hold_o is high throughout REQ and RESP except in the completion cycle.
- flush_i in REQ/RESP does not abort the bus transaction.

Store lanes, with off = addr[1:0]:
- byte: wstrb = 0001<<off, wdata = {4{d[7:0]}}
- half: wstrb = 0011<<off, wdata = {2{d[15:0]}}
- word: wstrb = 1111, wdata = d

Load extract:
- byte: rdata[8*off+7 : 8*off]
- half: rdata[16*off[1]+15 : 16*off[1]]
- Sign-extend for types 001/010; zero-extend for 101/110; word is passed through.

Alignment:
- Misaligned means half with off[0]=1, or word with off!=0.
- Handling is per MEM_MISALIGN_TRAP_EN.

Reset mid-transaction: the FSM drops to IDLE and any late rvalid is ignored.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined: a misaligned access issues no bus transaction and no write-back. misalign_o pulses high for one cycle in the cycle after acceptance, with misalign_addr_o = the byte address. hold_o stays 0 for that op.
- Undefined: the offending low address bits are forced to 0 (half: bit 0; word: bits 1:0) and the access proceeds aligned. misalign_o and misalign_addr_o are tied to 0.

Test Plan:
1. ALU op, ex_w_reg_enable_i=1, addr 5, data 0x1234 -> next cycle wb_reg_enable_o=1, addr 5, data 0x1234, hold_o=0.
2. Signed byte load from 0x1003, rdata 0x80FF_0000, gnt after 2 cycles, rvalid 1 cycle later -> bus_addr_o=0x1000, wstrb 0000; hold_o high until the rvalid cycle; then wb data 0xFFFF_FF80. The same access with type 101 -> 0x0000_0080.
3. Half store 0xABCD to 0x2002 -> bus_we_o=1, wstrb 1100, wdata 0xABCD_ABCD; wb_reg_enable_o stays 0.
4. Word load with gnt and rvalid in the same REQ cycle, rdata 0xDEAD_BEEF, dest x0 -> completes from REQ, wb_reg_enable_o=0.
5. Word load to 0x3001 -> with MEM_MISALIGN_TRAP_EN: no bus_req_o, misalign_o=1, misalign_addr_o=0x3001. Without it: bus_addr_o=0x3000 and a normal load.
6. rst asserted in RESP, then rvalid arrives after reset -> all outputs 0, IDLE, no write-back.
